// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial A-B subtractor, LSB first, one full-adder cell plus carry flop
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W:0]   diff
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    diff_q, diff_d;
    logic          done_q, done_d;
    logic          nb, s, cout;
`ifdef SERIAL_SUB_OVF_EN
    logic          cmsb_q, cmsb_d;
    logic          ovf_q, ovf_d;
`endif

    // Single full-adder cell: a + ~b + carry, carry seeded with 1 for two's complement.
    assign nb   = ~b_q[0];
    assign s    = a_q[0] ^ nb ^ carry_q;
    assign cout = (a_q[0] & nb) | (a_q[0] & carry_q) | (nb & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        cmsb_d  = cmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {s, res_q[W-1:1]};
                carry_d = cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                    cmsb_d  = carry_q;
`endif
                end
            end
            S_DONE: begin
                diff_d  = {~carry_q, res_q};
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d   = cmsb_q ^ carry_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            cmsb_q  <= cmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign diff = diff_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (W=4) against an arithmetic model
module tb_serial_sub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W:0]   diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_sub #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model_diff(input int x, input int y);
        return (W+1)'((x - y) & ((1 << (W + 1)) - 1));
    endfunction

    function automatic logic model_ovf(input int x, input int y);
        int sx, sy, r;
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        r  = sx - sy;
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    // Drives one op; reports latency in edges after the accepting edge (0 = no done),
    // the captured diff, whether done was one cycle wide and whether diff held before done.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [W:0] d, output int lat,
                         output logic one_wide, output logic held);
        logic [W:0] prev;
        @(negedge clk);
        a = xa; b = xb; start = 1'b1;
        prev = diff;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 0; held = 1'b1; d = '0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                d = diff;
            end else if (diff !== prev) begin
                held = 1'b0;
            end
        end
        @(posedge clk); #1;
        one_wide = !done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (diff !== '0) begin bad++; $display("FAIL reset_diff got=%b exp=0", diff); end
`ifdef SERIAL_SUB_OVF_EN
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        int          va[4] = '{9, 3, 0, 15};
        int          vb[4] = '{3, 9, 0, 15};
        logic [W:0]  ev[4] = '{5'b00110, 5'b11010, 5'b00000, 5'b00000};
        logic [W:0]  d;
        int          lat;
        logic        ow, hd;
        for (int i = 0; i < 4; i++) begin
            do_op(W'(va[i]), W'(vb[i]), d, lat, ow, hd);
            total++; if (lat != 5) begin bad++; $display("FAIL dir_latency a=%0d b=%0d got=%0d exp=5", va[i], vb[i], lat); end
            total++; if (d !== ev[i]) begin bad++; $display("FAIL dir_diff a=%0d b=%0d got=%b exp=%b", va[i], vb[i], d, ev[i]); end
            total++; if (ow !== 1'b1) begin bad++; $display("FAIL dir_done_width a=%0d b=%0d got=wide exp=one", va[i], vb[i]); end
        end
    endtask

    task automatic test_exhaustive;
        logic [W:0] d;
        int         lat;
        logic       ow, hd;
        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                do_op(W'(x), W'(y), d, lat, ow, hd);
                total++; if (d !== model_diff(x, y) || lat != 5) begin
                    bad++; $display("FAIL exh_diff a=%0d b=%0d got=%b lat=%0d exp=%b lat=5", x, y, d, lat, model_diff(x, y));
                end
                total++; if (ow !== 1'b1) begin bad++; $display("FAIL exh_done_width a=%0d b=%0d got=wide exp=one", x, y); end
                total++; if (hd !== 1'b1) begin bad++; $display("FAIL exh_diff_hold a=%0d b=%0d got=changed exp=held", x, y); end
            end
        end
    endtask

    task automatic test_random;
        logic [W:0]   d;
        int           lat;
        logic         ow, hd;
        logic [W-1:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom); y = W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(x, y, d, lat, ow, hd);
            total++; if (d !== model_diff(int'(x), int'(y))) begin
                bad++; $display("FAIL rnd_diff a=%0d b=%0d got=%b exp=%b", x, y, d, model_diff(int'(x), int'(y)));
            end
            total++; if (d[W] !== (x < y)) begin bad++; $display("FAIL rnd_borrow a=%0d b=%0d got=%0b exp=%0b", x, y, d[W], x < y); end
        end
    endtask

    task automatic test_start_held;
        logic [W-1:0] x, y;
        int           ndone, first;
        logic [W:0]   d;
        x = W'($urandom); y = W'($urandom);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; first = 0; d = '0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            total++; if (busy !== 1'b1 && i < 5) begin bad++; $display("FAIL held_busy cycle=%0d got=%0b exp=1", i, busy); end
            if (done) begin ndone++; if (first == 0) begin first = i; d = diff; end end
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        total++; if (ndone != 1 || first != 5) begin bad++; $display("FAIL held_done_count got=%0d at=%0d exp=1 at=5", ndone, first); end
        total++; if (d !== model_diff(int'(x), int'(y))) begin
            bad++; $display("FAIL held_diff a=%0d b=%0d got=%b exp=%b", x, y, d, model_diff(int'(x), int'(y)));
        end
    endtask

    task automatic test_reset_mid;
        int         seen;
        logic [W:0] d;
        int         lat;
        logic       ow, hd;
        do_op(W'(9), W'(3), d, lat, ow, hd);
        @(negedge clk);
        a = W'(14); b = W'(1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        total++; if (diff !== '0) begin bad++; $display("FAIL rstmid_diff got=%b exp=0", diff); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
        total++; if (diff !== '0) begin bad++; $display("FAIL rstmid_diff_after got=%b exp=0", diff); end
        do_op(W'(12), W'(5), d, lat, ow, hd);
        total++; if (d !== 5'b00111 || lat != 5) begin bad++; $display("FAIL rstmid_next_op got=%b lat=%0d exp=00111 lat=5", d, lat); end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int         va[3] = '{7, 4, 8};
        int         vb[3] = '{8, 2, 1};
        logic       eo[3] = '{1'b1, 1'b0, 1'b1};
        logic [W:0] d;
        int         lat;
        logic       ow, hd;
        logic [W-1:0] x, y;
        for (int i = 0; i < 3; i++) begin
            do_op(W'(va[i]), W'(vb[i]), d, lat, ow, hd);
            total++; if (ovf !== eo[i]) begin bad++; $display("FAIL ovf_dir a=%0d b=%0d got=%0b exp=%0b", va[i], vb[i], ovf, eo[i]); end
        end
        for (int i = 0; i < 30; i++) begin
            x = W'($urandom); y = W'($urandom);
            do_op(x, y, d, lat, ow, hd);
            total++; if (ovf !== model_ovf(int'(x), int'(y))) begin
                bad++; $display("FAIL ovf_rnd a=%0d b=%0d got=%0b exp=%0b", x, y, ovf, model_ovf(int'(x), int'(y)));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_random();
        test_start_held();
        test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
